// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin arbiter for a shared 16x1 mux path with registered one-hot grant.
// Ports: clk (clock); reset (sync, active-low); req[15:0] (requests); done (release pulse from the granted requester);
//        grant[15:0] (one-hot grant); addr[3:0] (mux select = granted index); valid (grant active).
// Optional: define MUX16_ARB_TIMEOUT_EN to force release after HOLD_MAX busy cycles.
module mux16_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  addr,
  output logic        valid
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, addr_n, pick;
  logic [15:0] grant_n, rot;
  logic valid_n, tmo, rel;
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end
`ifdef MUX16_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  assign tmo = cnt == 8'(HOLD_MAX - 1);
`else
  assign tmo = 1'b0;
`endif
  // Rotating req by ptr turns the round-robin scan into a plain lowest-bit search.
  assign rot = 16'({req, req} >> ptr);
  assign rel = done | ~req[addr] | tmo;
  always_comb begin
    pick = ptr;
    for (int i = 15; i >= 0; i--)
      if (rot[i]) pick = ptr + 4'(i);
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    addr_n  = addr;
    valid_n = valid;
    ptr_n   = ptr;
`ifdef MUX16_ARB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    if (state == IDLE) begin
      if (|req) begin
        state_n = BUSY;
        grant_n = 16'b1 << pick;
        addr_n  = pick;
        valid_n = 1'b1;
`ifdef MUX16_ARB_TIMEOUT_EN
        cnt_n   = 8'd0;
`endif
      end
    end else if (rel) begin
      state_n = IDLE;
      grant_n = 16'h0000;
      valid_n = 1'b0;
      ptr_n   = addr + 4'd1;
    end else begin
`ifdef MUX16_ARB_TIMEOUT_EN
      cnt_n   = cnt + 8'd1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 16'h0000;
      addr  <= 4'h0;
      valid <= 1'b0;
      ptr   <= 4'h0;
`ifdef MUX16_ARB_TIMEOUT_EN
      cnt   <= 8'd0;
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      addr  <= addr_n;
      valid <= valid_n;
      ptr   <= ptr_n;
`ifdef MUX16_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb_mux16_arbiter: directed vector table plus hold/timeout sequence for mux16_arbiter.
module tb_mux16_arbiter;
  logic clk = 1'b0;
  logic reset, done, valid;
  logic [15:0] req, grant;
  logic [3:0] addr;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] g;
    logic [3:0]  a;
    logic        v;
  } vec_t;
  vec_t vq[$];
  mux16_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .addr(addr), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic row(input logic r, input logic [15:0] q, input logic d,
                     input logic [15:0] g, input logic [3:0] a, input logic v);
    vq.push_back('{r, q, d, g, a, v});
  endtask
  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [15:0] q, input logic d);
    @(negedge clk);
    reset = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b0; req = '0; done = 1'b0;
    row(0, 16'h0000, 0, 16'h0000, 4'd0,  0);
    row(1, 16'h0000, 0, 16'h0000, 4'd0,  0);
    row(1, 16'h0020, 0, 16'h0020, 4'd5,  1);
    row(1, 16'h0020, 0, 16'h0020, 4'd5,  1);
    row(1, 16'h0020, 1, 16'h0000, 4'd5,  0);
    row(1, 16'h0061, 0, 16'h0040, 4'd6,  1);
    row(1, 16'h0061, 1, 16'h0000, 4'd6,  0);
    row(1, 16'h0061, 0, 16'h0001, 4'd0,  1);
    row(1, 16'h8001, 1, 16'h0000, 4'd0,  0);
    row(1, 16'h8001, 0, 16'h8000, 4'd15, 1);
    row(1, 16'h8001, 1, 16'h0000, 4'd15, 0);
    row(1, 16'h8001, 0, 16'h0001, 4'd0,  1);
    row(1, 16'h8001, 1, 16'h0000, 4'd0,  0);
    row(1, 16'h8001, 0, 16'h8000, 4'd15, 1);
    row(1, 16'h8001, 1, 16'h0000, 4'd15, 0);
    row(1, 16'h0020, 0, 16'h0020, 4'd5,  1);
    row(1, 16'h0048, 0, 16'h0000, 4'd5,  0);
    row(1, 16'h0048, 0, 16'h0040, 4'd6,  1);
    row(1, 16'h0048, 1, 16'h0000, 4'd6,  0);
    row(1, 16'h0048, 0, 16'h0008, 4'd3,  1);
    row(1, 16'h0048, 1, 16'h0000, 4'd3,  0);
    row(1, 16'h0200, 0, 16'h0200, 4'd9,  1);
    row(1, 16'h0A00, 0, 16'h0200, 4'd9,  1);
    row(1, 16'h0801, 0, 16'h0000, 4'd9,  0);
    row(1, 16'h0801, 0, 16'h0800, 4'd11, 1);
    row(1, 16'h0801, 1, 16'h0000, 4'd11, 0);
    row(1, 16'h0000, 1, 16'h0000, 4'd11, 0);
    row(1, 16'h0400, 1, 16'h0400, 4'd10, 1);
    row(0, 16'h0400, 0, 16'h0000, 4'd0,  0);
    row(1, 16'hFFFF, 0, 16'h0001, 4'd0,  1);
    row(1, 16'hFFFF, 0, 16'h0001, 4'd0,  1);
    row(1, 16'hFFFF, 1, 16'h0000, 4'd0,  0);
    row(1, 16'hFFFF, 0, 16'h0002, 4'd1,  1);
    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].req, vq[i].done);
      chk("grant", i, grant, vq[i].g);
      chk("addr",  i, 16'(addr), 16'(vq[i].a));
      chk("valid", i, 16'(valid), 16'(vq[i].v));
      if (valid) chk("onehot", i, grant, 16'h1 << addr);
    end
    step(0, 16'h0000, 0);
    chk("hold_reset", 0, 16'(valid), 16'h0);
    for (int k = 1; k <= 10; k++) begin
      step(1, 16'h0002, 0);
`ifdef MUX16_ARB_TIMEOUT_EN
      chk("hold_valid", k, 16'(valid), 16'((k % 5) != 0));
      chk("hold_grant", k, grant, (k % 5) != 0 ? 16'h0002 : 16'h0000);
`else
      chk("hold_valid", k, 16'(valid), 16'h1);
      chk("hold_grant", k, grant, 16'h0002);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
